// File: rtl/score_renderer_pkg.sv
// Shared geometry constants, BCD nibble type and the single-digit BCD step
// helper used by the score counter and the renderer.
package score_renderer_pkg;

  localparam int DIGIT_COUNT = 4;  // digits in the score field
  localparam int CELL_W      = 8;  // font columns per digit cell, gap included
  localparam int FONT_W      = 5;  // lit font columns per glyph
  localparam int FONT_H      = 5;  // font rows per glyph

  typedef logic [3:0] bcd_nibble_t;

  localparam bcd_nibble_t BCD_MAX = 4'd9;

  // Advance one BCD digit by carry_in; returns {carry_out, next_digit}.
  // Any value at or above 9 rolls over, so an illegal nibble self-heals.
  function automatic logic [4:0] bcd_digit_step(input bcd_nibble_t digit,
                                                 input logic        carry_in);
    logic [4:0] result;
    if (!carry_in) begin
      result = {1'b0, digit};
    end else if (digit >= BCD_MAX) begin
      result = {1'b1, 4'd0};
    end else begin
      result = {1'b0, digit + 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/digits10_case.sv
// 5x5 digit font ROM. Bit 4 of bits is the leftmost font column; rows 5-7
// and digit codes above 9 read as blank.
module digits10_case (
  input  logic [3:0] digit,
  input  logic [2:0] yofs,
  output logic [4:0] bits
);

  // Glyph lookup addressed by {digit, row}
  always_comb begin
    case ({digit, yofs})
      7'o00: bits = 5'b11111;
      7'o01: bits = 5'b10001;
      7'o02: bits = 5'b10001;
      7'o03: bits = 5'b10001;
      7'o04: bits = 5'b11111;
      7'o10: bits = 5'b01100;
      7'o11: bits = 5'b00100;
      7'o12: bits = 5'b00100;
      7'o13: bits = 5'b00100;
      7'o14: bits = 5'b11111;
      7'o20: bits = 5'b11111;
      7'o21: bits = 5'b00001;
      7'o22: bits = 5'b11111;
      7'o23: bits = 5'b10000;
      7'o24: bits = 5'b11111;
      7'o30: bits = 5'b11111;
      7'o31: bits = 5'b00001;
      7'o32: bits = 5'b11111;
      7'o33: bits = 5'b00001;
      7'o34: bits = 5'b11111;
      7'o40: bits = 5'b10001;
      7'o41: bits = 5'b10001;
      7'o42: bits = 5'b11111;
      7'o43: bits = 5'b00001;
      7'o44: bits = 5'b00001;
      7'o50: bits = 5'b11111;
      7'o51: bits = 5'b10000;
      7'o52: bits = 5'b11111;
      7'o53: bits = 5'b00001;
      7'o54: bits = 5'b11111;
      7'o60: bits = 5'b11111;
      7'o61: bits = 5'b10000;
      7'o62: bits = 5'b11111;
      7'o63: bits = 5'b10001;
      7'o64: bits = 5'b11111;
      7'o70: bits = 5'b11111;
      7'o71: bits = 5'b00001;
      7'o72: bits = 5'b00001;
      7'o73: bits = 5'b00001;
      7'o74: bits = 5'b00001;
      7'o100: bits = 5'b11111;
      7'o101: bits = 5'b10001;
      7'o102: bits = 5'b11111;
      7'o103: bits = 5'b10001;
      7'o104: bits = 5'b11111;
      7'o110: bits = 5'b11111;
      7'o111: bits = 5'b10001;
      7'o112: bits = 5'b11111;
      7'o113: bits = 5'b00001;
      7'o114: bits = 5'b11111;
      default: bits = 5'b00000;
    endcase
  end

endmodule

// File: rtl/score_renderer_bcd_counter4.sv
// Four-digit BCD score counter. clr beats inc; wrap pulses for the single
// cycle in which the value rolls from 9999 to 0000.
module bcd_counter4
  import score_renderer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] value,
  output logic        wrap
);

  logic [15:0] value_q, value_d;
  logic        wrap_q, wrap_d;
  logic        carry;
  logic [4:0]  step;

  // Next count: clear, or ripple a +1 through the digit carry chain
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    carry   = 1'b0;
    step    = 5'd0;
    if (clr) begin
      value_d = 16'h0000;
    end else if (inc) begin
      carry = 1'b1;
      for (int i = 0; i < DIGIT_COUNT; i++) begin
        step               = bcd_digit_step(value_q[i*4 +: 4], carry);
        value_d[i*4 +: 4]  = step[3:0];
        carry              = step[4];
      end
      wrap_d = carry;
    end else begin
      value_d = value_q;
    end
  end

  // Count and wrap-pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= 16'h0000;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  end

  assign value = value_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/score_renderer.sv
// Score field renderer: holds the BCD score, latches a frame-stable copy at
// the top-left of each frame and draws it as four scaled 5x5 glyphs.
module score_renderer
  import score_renderer_pkg::*;
#(
  parameter int X0    = 16,
  parameter int Y0    = 16,
  parameter int SHIFT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic        display_on,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] score,
  output logic        overflow,
  output logic        pixel
);

  // Field bounds widened to 32 bits so the comparisons never wrap
  localparam logic [31:0] X_LO = 32'(X0);
  localparam logic [31:0] X_HI = 32'(X0 + ((DIGIT_COUNT * CELL_W) << SHIFT));
  localparam logic [31:0] Y_LO = 32'(Y0);
  localparam logic [31:0] Y_HI = 32'(Y0 + (FONT_H << SHIFT));

  logic [15:0] disp_q, disp_d;
  logic        pixel_q, pixel_d;
  logic [31:0] hpos_w, vpos_w;
  logic        field_active;
  logic [4:0]  col;
  logic [2:0]  row;
  bcd_nibble_t nibble;
  logic        nibble_valid;
  bcd_nibble_t font_digit;
  logic [4:0]  font_bits;

  bcd_counter4 u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .clr   (clr),
    .value (score),
    .wrap  (overflow)
  );

  // Beam position to field-local font column and row
  always_comb begin
    hpos_w       = {23'd0, hpos};
    vpos_w       = {23'd0, vpos};
    field_active = (hpos_w >= X_LO) && (hpos_w < X_HI) &&
                   (vpos_w >= Y_LO) && (vpos_w < Y_HI);
    col          = 5'((hpos_w - X_LO) >> SHIFT);
    row          = 3'((vpos_w - Y_LO) >> SHIFT);
  end

  // Pick the displayed digit; out-of-range nibbles are drawn blank
  always_comb begin
    case (col[4:3])
      2'd0:    nibble = disp_q[15:12];
      2'd1:    nibble = disp_q[11:8];
      2'd2:    nibble = disp_q[7:4];
      2'd3:    nibble = disp_q[3:0];
      default: nibble = 4'd0;
    endcase
    nibble_valid = (nibble <= BCD_MAX);
    if (nibble_valid) begin
      font_digit = nibble;
    end else begin
      font_digit = 4'd0;
    end
  end

  digits10_case u_font (
    .digit (font_digit),
    .yofs  (row),
    .bits  (font_bits)
  );

  // Frame-start shadow load and next video bit
  always_comb begin
    if ((hpos == 9'd0) && (vpos == 9'd0)) begin
      disp_d = score;
    end else begin
      disp_d = disp_q;
    end
    if (field_active && display_on && nibble_valid && (col[2:0] < 3'(FONT_W))) begin
      pixel_d = font_bits[3'd4 - col[2:0]];
    end else begin
      pixel_d = 1'b0;
    end
  end

  // Shadow score and video output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q  <= 16'h0000;
      pixel_q <= 1'b0;
    end else begin
      disp_q  <= disp_d;
      pixel_q <= pixel_d;
    end
  end

  assign pixel = pixel_q;

endmodule

// File: tb/tb_score_renderer.sv
// Self-checking bench for score_renderer: directed scenarios plus a random
// phase, every cycle compared against a decimal/bitmap reference model.
module tb_score_renderer;

  logic        clk;
  logic        reset;
  logic [8:0]  hpos;
  logic [8:0]  vpos;
  logic        display_on;
  logic        inc;
  logic        clr;
  logic [15:0] score;
  logic        overflow;
  logic        pixel;

  int passed = 0;
  int total  = 0;

  // reference state: plain decimal integers
  int score_m = 0;
  int disp_m  = 0;
  bit ov_m    = 1'b0;
  bit pix_m   = 1'b0;

  // glyph bitmaps, row 0 first, leftmost column as MSB of each row
  bit [24:0] glyph [0:9] = '{
    25'b11111_10001_10001_10001_11111,
    25'b01100_00100_00100_00100_11111,
    25'b11111_00001_11111_10000_11111,
    25'b11111_00001_11111_00001_11111,
    25'b10001_10001_11111_00001_00001,
    25'b11111_10000_11111_00001_11111,
    25'b11111_10000_11111_10001_11111,
    25'b11111_00001_00001_00001_00001,
    25'b11111_10001_11111_10001_11111,
    25'b11111_10001_11111_00001_11111
  };

  score_renderer #(.X0(16), .Y0(16), .SHIFT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .inc        (inc),
    .clr        (clr),
    .score      (score),
    .overflow   (overflow),
    .pixel      (pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 +
               ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic bit model_pixel(input int h, input int v, input bit on, input int d);
    int col, row, idx, fc, dig, p10;
    if (!on) return 1'b0;
    if (h < 16 || h >= 16 + 256 || v < 16 || v >= 16 + 40) return 1'b0;
    col = (h - 16) / 8;
    row = (v - 16) / 8;
    idx = col / 8;
    fc  = col % 8;
    if (fc >= 5) return 1'b0;
    p10 = (idx == 0) ? 1000 : (idx == 1) ? 100 : (idx == 2) ? 10 : 1;
    dig = (d / p10) % 10;
    return glyph[dig][24 - (row * 5 + fc)];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // one clock: predict from current inputs, advance, compare all outputs
  task automatic tick();
    int score_n, disp_n;
    bit ov_n, pix_n;
    if (reset) begin
      score_n = 0; disp_n = 0; ov_n = 1'b0; pix_n = 1'b0;
    end else begin
      pix_n = model_pixel(int'(hpos), int'(vpos), display_on, disp_m);
      ov_n  = 1'b0;
      if (clr) score_n = 0;
      else if (inc) begin
        if (score_m == 9999) begin score_n = 0; ov_n = 1'b1; end
        else score_n = score_m + 1;
      end else score_n = score_m;
      disp_n = (hpos == 9'd0 && vpos == 9'd0) ? score_m : disp_m;
    end
    @(posedge clk);
    #1;
    score_m = score_n; disp_m = disp_n; ov_m = ov_n; pix_m = pix_n;
    check("score", {16'd0, score}, {16'd0, to_bcd(score_m)});
    check("overflow", {31'd0, overflow}, {31'd0, ov_m});
    check("pixel", {31'd0, pixel}, {31'd0, pix_m});
  endtask

  initial begin
    reset = 1'b1; hpos = 9'd400; vpos = 9'd400; display_on = 1'b1;
    inc = 1'b0; clr = 1'b0;

    // reset state
    for (int i = 0; i < 3; i++) tick();
    check("rst_score", {16'd0, score}, 32'h0000);
    check("rst_pixel", {31'd0, pixel}, 32'd0);
    reset = 1'b0;

    // 1234 increments
    inc = 1'b1;
    for (int i = 0; i < 1234; i++) tick();
    inc = 1'b0;
    tick();
    check("cnt_1234", {16'd0, score}, 32'h1234);

    // climb to 9999 then wrap
    clr = 1'b1; tick(); clr = 1'b0;
    inc = 1'b1;
    for (int i = 0; i < 9999; i++) tick();
    check("cnt_9999", {16'd0, score}, 32'h9999);
    tick();
    check("wrap_score", {16'd0, score}, 32'h0000);
    check("wrap_ovf", {31'd0, overflow}, 32'd1);
    inc = 1'b0;
    tick();
    check("wrap_ovf_drop", {31'd0, overflow}, 32'd0);

    // clr beats inc
    inc = 1'b1;
    for (int i = 0; i < 42; i++) tick();
    check("cnt_0042", {16'd0, score}, 32'h0042);
    clr = 1'b1; tick(); clr = 1'b0; inc = 1'b0;
    check("clr_inc_score", {16'd0, score}, 32'h0000);
    check("clr_inc_ovf", {31'd0, overflow}, 32'd0);

    // show 1000: scan row 0 of the thousands digit and the gap
    inc = 1'b1;
    for (int i = 0; i < 1000; i++) tick();
    inc = 1'b0;
    hpos = 9'd0; vpos = 9'd0; tick();
    vpos = 9'd16;
    for (int h = 16; h <= 79; h++) begin
      hpos = 9'(h);
      tick();
      check("row0_1000", {31'd0, pixel}, {31'd0, (h >= 24 && h < 40)});
    end

    // mid-frame score change must not show until next frame start
    hpos = 9'd300; vpos = 9'd20; inc = 1'b1; tick(); inc = 1'b0;
    for (int h = 16; h <= 271; h++) begin
      hpos = 9'(h);
      tick();
      if (h == 208) check("no_tear_units", {31'd0, pixel}, 32'd1);
    end
    hpos = 9'd0; vpos = 9'd0; tick();
    vpos = 9'd20;
    for (int h = 16; h <= 271; h++) begin
      hpos = 9'(h);
      tick();
      if (h == 208) check("new_frame_units", {31'd0, pixel}, 32'd0);
    end

    // blanking and field edges
    hpos = 9'd24; vpos = 9'd16; display_on = 1'b0; tick();
    check("disp_off", {31'd0, pixel}, 32'd0);
    display_on = 1'b1; hpos = 9'd15; tick();
    check("left_edge", {31'd0, pixel}, 32'd0);
    hpos = 9'd24; vpos = 9'd55; tick();
    check("last_row", {31'd0, pixel}, 32'd1);
    vpos = 9'd56; tick();
    check("below_field", {31'd0, pixel}, 32'd0);

    // reset mid-frame blanks, then 0000 is shown
    vpos = 9'd16; tick();
    check("pre_reset_px", {31'd0, pixel}, 32'd1);
    reset = 1'b1; tick();
    check("reset_px", {31'd0, pixel}, 32'd0);
    reset = 1'b0; hpos = 9'd16; tick();
    check("post_reset_px", {31'd0, pixel}, 32'd1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      inc        = ($urandom_range(0, 3) == 0);
      clr        = ($urandom_range(0, 63) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      display_on = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) begin
        hpos = 9'd0; vpos = 9'd0;
      end else begin
        hpos = 9'($urandom_range(0, 300));
        vpos = 9'($urandom_range(0, 70));
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
